// File: rtl/rv523_pkg.sv
// Shared constants for the RV523 shift unit: datapath width, op encoding and FSM states.
// The optional fast-step feature is selected with the RV523_SHIFT_FAST_EN macro.
package rv523_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_RSV = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/rv523_shift_step.sv
// Combinational single-step shifter: one bit per step, or four when RV523_SHIFT_FAST_EN
// is defined and step4 is set.
module rv523_shift_step
  import rv523_pkg::*;
#(
  parameter int XLEN = rv523_pkg::XLEN
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      op,
  input  logic            step4,
  output logic [XLEN-1:0] result
);

`ifndef RV523_SHIFT_FAST_EN
  logic unused_step4;
  assign unused_step4 = step4;
`endif

  always_comb begin
    result = data;
    case (op)
      OP_SLL:  result = {data[XLEN-2:0], 1'b0};
      OP_SRL:  result = {1'b0, data[XLEN-1:1]};
      OP_SRA:  result = {data[XLEN-1], data[XLEN-1:1]};
      default: result = data;
    endcase
`ifdef RV523_SHIFT_FAST_EN
    if (step4) begin
      case (op)
        OP_SLL:  result = {data[XLEN-5:0], 4'b0000};
        OP_SRL:  result = {4'b0000, data[XLEN-1:4]};
        OP_SRA:  result = {{4{data[XLEN-1]}}, data[XLEN-1:4]};
        default: result = data;
      endcase
    end
`endif
  end

endmodule

// File: rtl/rv523_shift_unit.sv
// Iterative shift unit with valid/ready handshakes on both sides (IDLE -> SHIFT -> DONE).
// Defining RV523_SHIFT_FAST_EN enables 4-bit steps while the remaining count is at least 4.
module rv523_shift_unit
  import rv523_pkg::*;
#(
  parameter int XLEN = rv523_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_data,
  input  logic [4:0]      in_shamt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data
);

  shift_state_t    state;
  logic [4:0]      count;
  logic [1:0]      op_q;
  logic [XLEN-1:0] work;
  logic [XLEN-1:0] step_out;
  logic            step4;
  logic [4:0]      step_amt;

`ifdef RV523_SHIFT_FAST_EN
  assign step4 = |count[4:2];
`else
  assign step4 = 1'b0;
`endif

  assign step_amt = step4 ? 5'd4 : 5'd1;
  assign out_data = work;

  rv523_shift_step #(.XLEN(XLEN)) u_step (
    .data   (work),
    .op     (op_q),
    .step4  (step4),
    .result (step_out)
  );

  // Reserved op and zero shamt skip SHIFT so the result is ready one cycle after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= 5'd0;
      op_q      <= OP_SLL;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q     <= in_op;
            work     <= in_data;
            in_ready <= 1'b0;
            if ((in_op == OP_RSV) || (in_shamt == 5'd0)) begin
              count     <= 5'd0;
              state     <= ST_DONE;
              out_valid <= 1'b1;
            end else begin
              count <= in_shamt;
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          work  <= step_out;
          count <= count - step_amt;
          if (count == step_amt) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          count     <= 5'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv523_shift_unit.sv
// Self-checking bench for rv523_shift_unit: directed cases, reset abort and randomized
// traffic with backpressure against an arithmetic reference model.
module tb_rv523_shift_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks;
  int errors;
  int results;

  rv523_shift_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] d,
                                             input int sh);
    case (op)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b11:   return $unsigned($signed(d) >>> sh);
      default: return d;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input int sh);
    if (op == 2'b10) return 1;
`ifdef RV523_SHIFT_FAST_EN
    return sh / 4 + sh % 4 + 1;
`else
    return sh + 1;
`endif
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; noise drives ignored inputs randomly while not in IDLE.
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] d, input int sh,
                                input int stall, input bit noise);
    logic [31:0] exp_data;
    int          exp_lat;
    int          lat;
    int          guard;
    exp_data = ref_result(op, d, sh);
    exp_lat  = (sh == 0) ? 1 : ref_latency(op, sh);
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    check_output("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = sh[4:0];
    tick();
    lat = 1;
    while (!out_valid && lat < 64) begin
      in_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = $urandom;
      out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_output("latency", 32'(lat), 32'(exp_lat));
    check_output("result", out_data, exp_data);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      tick();
      check_output("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check_output("stall_out_data", out_data, exp_data);
      check_output("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    results++;
    out_ready = 1'b0;
    check_output("post_handshake_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("post_handshake_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int seen_valid;
    int ops;
    checks    = 0;
    errors    = 0;
    results   = 0;
    ops       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_data   = 32'd0;
    in_shamt  = 5'd0;
    out_ready = 1'b0;

    #12;
    check_output("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("reset_out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    $display("[TB] directed cases");
    apply_stimulus(2'b00, 32'h0000_0001, 4, 0, 1'b0);
    apply_stimulus(2'b11, 32'h8000_0000, 31, 0, 1'b0);
    apply_stimulus(2'b01, 32'h8000_0000, 31, 0, 1'b0);
    apply_stimulus(2'b00, 32'hDEAD_BEEF, 0, 0, 1'b0);
    apply_stimulus(2'b10, 32'hDEAD_BEEF, 7, 0, 1'b0);
    apply_stimulus(2'b11, 32'h7FFF_FFF0, 3, 0, 1'b0);
    apply_stimulus(2'b01, 32'hF0F0_1234, 1, 10, 1'b0);
    ops += 7;

    $display("[TB] reset during shift");
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_data  = 32'hABCD_5678;
    in_shamt = 5'd20;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_output("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("abort_out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) seen_valid++;
    end
    check_output("abort_no_result", 32'(seen_valid), 32'd0);
    apply_stimulus(2'b01, 32'hABCD_5678, 20, 0, 1'b0);
    ops++;

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      apply_stimulus(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 31),
                     $urandom_range(0, 3), 1'b1);
      ops++;
    end
    check_output("result_count", 32'(results), 32'(ops));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv523_shift_unit.md
RV523_SHIFT_UNIT -- requirements
Module: rv523_shift_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the datapath width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the unit accepts a request.
REQ-006 SHALL have port in_op, input, 2 bits: 00 SLL, 01 SRL, 11 SRA, 10 reserved.
REQ-007 SHALL have port in_data, input, XLEN bits: the operand.
REQ-008 SHALL have port in_shamt, input, 5 bits: the shift amount, 0..31.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port out_data, output, XLEN bits: the result.

Function
REQ-012 SHALL transfer a request only on a cycle where in_valid=1 and in_ready=1, latching op, data and shamt.
REQ-013 SHALL be an FSM with states IDLE, SHIFT and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 IDLE transition on an accepted request: to SHIFT if shamt≠0, otherwise to DONE.
REQ-015 SHIFT behaviour, per cycle: shift the working register by one bit and decrement the count; when the count reaches 0, go to DONE.
REQ-016 Shift fill rules: SLL fills 0 at the LSB; SRL fills 0 at the MSB; SRA replicates the MSB.
REQ-017 Op 10 SHALL yield in_data unchanged with zero SHIFT cycles, regardless of shamt.
REQ-018 Latency: out_valid SHALL rise exactly shamt+1 cycles after the accept edge; the minimum is 1 cycle, for shamt=0.
REQ-019 DONE SHALL hold out_data stable until out_valid and out_ready are both 1, then return to IDLE.
REQ-020 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-021 The DONE→IDLE cycle and a new accept SHALL NOT coincide; back-to-back throughput is one result per shamt+2 cycles minimum.
REQ-022 out_data SHALL equal the working register and be 0 in IDLE after reset.

Reset
REQ-023 rst=1 SHALL force IDLE, count=0, working register=0, in_ready=1 and out_valid=0, asynchronously.
REQ-024 A reset asserted mid-SHIFT or mid-DONE SHALL discard the operation with no result produced.
REQ-025 Reset deassertion SHALL be used synchronously; the first accept is possible on the first edge after release.

Configuration
REQ-026 SHALL have macro RV523_SHIFT_FAST_EN.
REQ-027 With RV523_SHIFT_FAST_EN defined, each SHIFT cycle SHALL shift by 4 when count≥4, else by 1.
REQ-028 With RV523_SHIFT_FAST_EN defined, latency SHALL be floor(shamt/4)+(shamt mod 4)+1.
REQ-029 With RV523_SHIFT_FAST_EN undefined, behaviour SHALL be exactly REQ-015 and REQ-018, with no 4-bit step logic synthesized.
REQ-030 Results SHALL be identical in both configurations.

Structure
REQ-031 Package rv523_pkg SHALL hold: the XLEN constant, the shift-op encoding constants (SLL/SRL/RSV/SRA), and the shift FSM state encoding.
REQ-032 SHALL have sub-module rv523_shift_step, purely combinational: inputs data, op and a step-of-4 flag; output the shifted data.
REQ-033 rv523_shift_unit SHALL instantiate rv523_shift_step once.
REQ-034 The RTL SHALL map onto RV523 cells plus flip-flops only; no multiplier and no wide barrel shifter.

Verification
REQ-035 SLL 0x0000_0001 by 4 -> out_data 0x0000_0010; out_valid 5 cycles after accept (fast: 2).
REQ-036 SRA 0x8000_0000 by 31 -> 0xFFFF_FFFF; SRL with the same inputs -> 0x0000_0001; latency 32 cycles (fast: 11).
REQ-037 SLL 0xDEAD_BEEF by 0 -> 0xDEAD_BEEF after 1 cycle; op 10 with shamt 7 -> 0xDEAD_BEEF after 1 cycle.
REQ-038 out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0 and in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-039 rst pulsed at cycle 3 of a 20-bit SRL -> out_valid never asserts, in_ready=1 immediately, the next request completes correctly.
REQ-040 Random ops, operands and shamts with random out_ready backpressure -> every result matches the reference model, with no lost or duplicated results.
